porta_uart_tx: RTL and testbench

Serial output stage for the 8-bit processor. It sits directly downstream of the PORTA output register and consumes the same write strobe and accumulator byte that load PORTA. Accepted bytes are buffered in a small FIFO and shifted out as 8N1 UART frames. Its status byte is wired back through the PORTA_IN path, so programs can poll for buffer space.

---
 rtl/porta_uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/porta_uart_tx.sv | 138 +++++++++++++
 tb/tb_porta_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/porta_uart_pkg.sv
// Shared constants for the PORTA serial output stage: FSM state encodings
// and bit positions of the status byte read back through PORTA_IN.
package porta_uart_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output. A push into a
// full FIFO is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_AW    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      count
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; count and pointers
    // define validity, and a reset-free array maps onto plain register files.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH);
    assign empty = (count == '0);

endmodule

// File: rtl/porta_uart_tx.sv
// PORTA serial output stage: queues bytes written alongside PORTA and shifts
// them out as 8N1 UART frames; status byte is polled through PORTA_IN.
module porta_uart_tx
    import porta_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  CLR_OVF,
    output logic                  TX,
    output logic                  BUSY,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVF,
    output logic [DATA_WIDTH-1:0] STATUS
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT  = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [TW-1:0]         timer;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  tx_q;
    logic                  ovf_q;
    logic                  bit_done;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_AW:0]      fifo_count;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (WR),
        .pop   (fifo_pop),
        .din   (DATA_IN),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The shifted byte leaves the FIFO on the pop, freeing its slot at once.
    assign fifo_pop = (state == S_IDLE) && !fifo_empty;
    assign bit_done = (timer == TIMER_LAST);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (WR && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            else if (CLR_OVF)                 ovf_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
                        timer <= '0;
                        tx_q  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx_q    <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == BIT_LAST) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (bit_done) begin
                        timer <= '0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign TX    = tx_q;
    assign OVF   = ovf_q;
    assign EMPTY = fifo_empty;
    assign FULL  = (fifo_count == DEPTH_CNT);
    assign BUSY  = (state != S_IDLE) || !fifo_empty;

    // NOTE: default the whole byte first so no bit is left unassigned on any
    // path, which would otherwise infer a latch.
    always_comb begin
        STATUS          = '0;
        STATUS[ST_BUSY] = BUSY;
        STATUS[ST_FULL] = FULL;
        STATUS[ST_OVF]  = OVF;
    end

endmodule

// File: tb/tb_porta_uart_tx.sv
// Self-checking bench for porta_uart_tx: a line monitor decodes frames and
// compares them against a scoreboard of bytes expected to be transmitted.
module tb_porta_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       CLR_OVF = 1'b0;
    logic       TX, BUSY, FULL, EMPTY, OVF;
    logic [7:0] STATUS;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_frames = 0;
    int         wr_cyc;
    logic [7:0] exp_q[$];
    int         starts[$];

    porta_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .FIFO_AW      (2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR      (WR),
        .DATA_IN (DATA_IN),
        .CLR_OVF (CLR_OVF),
        .TX      (TX),
        .BUSY    (BUSY),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .OVF     (OVF),
        .STATUS  (STATUS)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame monitor: captures 10*CPB line samples from the start bit and
    // decodes mid-bit; a frame cut by reset is discarded.
    initial begin
        logic       line [FRAME];
        logic [7:0] b;
        bit         aborted;
        forever begin
            @(negedge CLK);
            if (!RST && TX === 1'b0) begin
                starts.push_back(cyc);
                aborted = 1'b0;
                line[0] = 1'b0;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge CLK);
                    line[j] = TX;
                    if (RST) aborted = 1'b1;
                end
                if (!aborted) begin
                    for (int i = 0; i < 8; i++) b[i] = line[CPB * (i + 1) + CPB / 2];
                    n_frames++;
                    check("start_bit", 32'(line[CPB / 2]), 32'd0);
                    check("stop_bit", 32'(line[9 * CPB + CPB / 2]), 32'd1);
                    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_wr(input logic [7:0] b, input bit accept);
        WR = 1'b1;
        DATA_IN = b;
        wr_cyc = cyc + 1;
        if (accept) exp_q.push_back(b);
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY !== 1'b0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s0, f0;

        // Reset values
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_status", 32'(STATUS), 32'h00);
        check("rst_empty", 32'(EMPTY), 32'd1);
        @(negedge CLK);

        // Single byte 0xA5
        drive_wr(8'hA5, 1'b1);
        k = wr_cyc;
        check("single_empty", 32'(EMPTY), 32'd0);
        @(negedge CLK);
        check("single_empty_after_pop", 32'(EMPTY), 32'd1);
        wait_cyc(k + FRAME);
        check("single_busy_in_stop", 32'(BUSY), 32'd1);
        wait_cyc(k + FRAME + 1);
        check("single_busy_done", 32'(BUSY), 32'd0);
        wait_idle(200);
        check("single_start_delay", 32'(starts[0] - k), 32'd1);

        // Back-to-back burst of five
        s0 = starts.size();
        for (int i = 1; i <= 5; i++) drive_wr(8'(i), 1'b1);
        wait_idle(400);
        check("burst_frames", 32'(starts.size() - s0), 32'd5);
        for (int i = 1; i < 5 && s0 + i < starts.size(); i++)
            check("burst_pitch", 32'(starts[s0 + i] - starts[s0 + i - 1]), 32'(FRAME + 1));
        check("burst_ovf", 32'(OVF), 32'd0);

        // Overflow: 0x15 is dropped
        for (int i = 0; i < 6; i++) drive_wr(8'h10 + 8'(i), i != 5);
        check("ovf_set", 32'(OVF), 32'd1);
        check("ovf_status", 32'(STATUS), 32'h07);
        check("ovf_full", 32'(FULL), 32'd1);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        check("ovf_clear", 32'(OVF), 32'd0);
        wait_idle(400);

        // Push/pop collision on the IDLE pop cycle
        for (int i = 0; i < 5; i++) drive_wr(8'hA0 + 8'(i), 1'b1);
        k = wr_cyc - 4;
        wait_cyc(k + FRAME + 1);
        check("coll_full_before", 32'(FULL), 32'd1);
        drive_wr(8'hA5, 1'b1);
        check("coll_full_after", 32'(FULL), 32'd1);
        check("coll_ovf", 32'(OVF), 32'd0);
        check("coll_status", 32'(STATUS), 32'h03);
        wait_idle(500);

        // Reset during DATA bit 3
        for (int i = 0; i < 3; i++) drive_wr(8'h55 + 8'(i * 17), 1'b1);
        k = wr_cyc - 2;
        wait_cyc(k + 18);
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        check("midrst_tx", 32'(TX), 32'd1);
        check("midrst_empty", 32'(EMPTY), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_status", 32'(STATUS), 32'h00);
        f0 = n_frames;
        repeat (60) @(negedge CLK);
        check("midrst_no_frames", 32'(n_frames - f0), 32'd0);
        check("midrst_tx_idle", 32'(TX), 32'd1);
        drive_wr(8'h3C, 1'b1);
        wait_idle(200);

        check("total_frames", 32'(n_frames), 32'd18);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
